// File: rtl/conv_window3x3_if.sv
// Pixel-stream-in / window-taps-out bundle for the 3x3 window front end.
// master drives pixels and observes taps; slave is the window generator.
interface conv_window3x3_if #(
  parameter int DW = 8
);
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          sof;

  logic [DW-1:0] pix_4_weight;
  logic [DW-1:0] pix_2_weight1;
  logic [DW-1:0] pix_2_weight2;
  logic [DW-1:0] pix_2_weight3;
  logic [DW-1:0] pix_2_weight4;
  logic [DW-1:0] pix_1_weight1;
  logic [DW-1:0] pix_1_weight2;
  logic [DW-1:0] pix_1_weight3;
  logic [DW-1:0] pix_1_weight4;
  logic          win_valid;
  logic          frame_done;

  // Handshake: pix_valid-only push, no back-pressure; a pixel is taken on every
  // rising clk edge with pix_valid=1. win_valid qualifies the taps for one cycle.
  modport master (
    output pix_in, pix_valid, sof,
    input  pix_4_weight,
    input  pix_2_weight1, pix_2_weight2, pix_2_weight3, pix_2_weight4,
    input  pix_1_weight1, pix_1_weight2, pix_1_weight3, pix_1_weight4,
    input  win_valid, frame_done
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output pix_4_weight,
    output pix_2_weight1, pix_2_weight2, pix_2_weight3, pix_2_weight4,
    output pix_1_weight1, pix_1_weight2, pix_1_weight3, pix_1_weight4,
    output win_valid, frame_done
  );
endinterface

// File: rtl/conv_window3x3.sv
// Raster-to-3x3-window converter: two line buffers feed a 3x3 shift array whose
// taps are presented grouped by mask weight class, valid only for interior centres.
module conv_window3x3 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  conv_window3x3_if.slave  bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d, c_cur;
  logic [RW-1:0] row_q, row_d, r_cur;

  // LB0 holds row r-1, LB1 holds row r-2; contents survive reset on purpose.
  logic [DW-1:0] lb0 [IMG_W];
  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] lb0_rd, lb1_rd;

  // Index 2 is the newest (right) column, index 0 the oldest (left).
  logic [2:0][DW-1:0] top_q, top_d;
  logic [2:0][DW-1:0] mid_q, mid_d;
  logic [2:0][DW-1:0] bot_q, bot_d;

  logic win_valid_q, win_valid_d;
  logic frame_done_q, frame_done_d;

  always_comb begin
    c_cur        = bus.sof ? '0 : col_q;
    r_cur        = bus.sof ? '0 : row_q;
    lb0_rd       = lb0[c_cur];
    lb1_rd       = lb1[c_cur];
    col_d        = col_q;
    row_d        = row_q;
    top_d        = top_q;
    mid_d        = mid_q;
    bot_d        = bot_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    if (bus.pix_valid) begin
      if (c_cur == COL_LAST) begin
        col_d = '0;
        row_d = (r_cur == ROW_LAST) ? '0 : r_cur + RW'(1);
      end else begin
        col_d = c_cur + CW'(1);
        row_d = r_cur;
      end

      top_d = {lb1_rd,     top_q[2], top_q[1]};
      mid_d = {lb0_rd,     mid_q[2], mid_q[1]};
      bot_d = {bus.pix_in, bot_q[2], bot_q[1]};

      // Rows/cols 0 and 1 would pull in data from a previous line or frame.
      win_valid_d  = (r_cur >= RW'(2)) && (c_cur >= CW'(2));
      frame_done_d = (r_cur == ROW_LAST) && (c_cur == COL_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      top_q        <= '0;
      mid_q        <= '0;
      bot_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      top_q        <= top_d;
      mid_q        <= mid_d;
      bot_q        <= bot_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.pix_valid && !rst) begin
      lb1[c_cur] <= lb0_rd;
      lb0[c_cur] <= bus.pix_in;
    end
  end

  assign bus.pix_4_weight  = mid_q[1];
  assign bus.pix_2_weight1 = top_q[1];
  assign bus.pix_2_weight2 = mid_q[0];
  assign bus.pix_2_weight3 = mid_q[2];
  assign bus.pix_2_weight4 = bot_q[1];
  assign bus.pix_1_weight1 = top_q[0];
  assign bus.pix_1_weight2 = top_q[2];
  assign bus.pix_1_weight3 = bot_q[0];
  assign bus.pix_1_weight4 = bot_q[2];
  assign bus.win_valid     = win_valid_q;
  assign bus.frame_done    = frame_done_q;

endmodule

// File: doc/conv_window3x3.md
Name: conv_window3x3

Overview:
- Raster-to-window front end for the ISP 3x3 convolution masks.
- Accepts one pixel per valid cycle in raster order and keeps two line buffers plus a 3x3 shift array.
- Presents the nine window taps to the mask stage, grouped by mask weight class: one centre tap, four edge taps and four corner taps.
- Emits a window only for interior centre pixels.
- Marks the last window of each frame with a pulse.

Parameters:
- IMG_W, 640, active pixels per line (>=3)
- IMG_H, 480, active lines per frame (>=3)
- DW, 8, pixel width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- pix_in  in  DW  input pixel
- pix_valid  in  1  pix_in valid this cycle
- sof  in  1  start of frame; qualified by pix_valid, marks that pixel as (0,0)
- pix_4_weight  out  DW  centre tap (r-1,c-1)
- pix_2_weight1  out  DW  north (r-2,c-1)
- pix_2_weight2  out  DW  west (r-1,c-2)
- pix_2_weight3  out  DW  east (r-1,c)
- pix_2_weight4  out  DW  south (r,c-1)
- pix_1_weight1  out  DW  north-west (r-2,c-2)
- pix_1_weight2  out  DW  north-east (r-2,c)
- pix_1_weight3  out  DW  south-west (r,c-2)
- pix_1_weight4  out  DW  south-east (r,c)
- win_valid  out  1  taps form a valid interior window this cycle
- frame_done  out  1  single-cycle pulse coincident with the last window of a frame

Behaviour:
- Reset (async, rst=1):
  - col, row counters = 0.
  - All nine taps, win_valid and frame_done = 0.
  - Line-buffer contents are not cleared.
- Acceptance: a pixel is accepted on any rising clk edge with pix_valid=1. No back-pressure. With pix_valid=0 the block holds all state, counters and taps.
- Position of the accepted pixel (r,c):
  - If sof=1, the pixel is (0,0).
  - Otherwise it is the current (row,col).
  - After acceptance, col increments. At col=IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both counters return to 0. A following pixel without sof is treated as the next frame.
- Line buffers: two DW x IMG_W arrays, LB0 holds row r-1 and LB1 holds row r-2. On acceptance at column c:
  - Read LB0[c] and LB1[c] before writing.
  - Write LB1[c] <= old LB0[c] and LB0[c] <= pix_in.
- Window array: 3x3 registers, shifted one column left per accepted pixel. The new right column is {old LB1[c], old LB0[c], pix_in}, ordered top, middle, bottom.
- Latency: taps and win_valid are registered. They reflect the pixel accepted at edge N during the cycle after edge N, i.e. 1 cycle.
- win_valid:
  - 1 for exactly one cycle per accepted pixel with r>=2 and c>=2.
  - 0 in all other cycles, including idle cycles.
  - Windows per frame = (IMG_H-2)*(IMG_W-2).
- Taps when win_valid=0: they hold their last shifted values and carry no meaning. Downstream uses win_valid only.
- frame_done: asserted together with win_valid for the window produced by input (IMG_H-1, IMG_W-1).
- Row change: window columns from the previous line are shifted out naturally. Because c<2 suppresses win_valid, the first two pixels of each line never produce a window.
- Mid-frame sof: counters restart at (0,0) with the sof pixel. No window is emitted until row 2 of the new frame, so stale line-buffer data is never presented as valid.
- Simultaneous sof and wrap: sof has priority over the wrap/increment.
- Reset mid-frame: all outputs drop to 0 asynchronously. The next accepted pixel is (0,0) whether or not sof is set.
- Widths: counters are clog2(IMG_W) and clog2(IMG_H) bits. No arithmetic is performed on pixel data.

Test Plan:
1. IMG_W=5, IMG_H=4. Stream pix=10*r+c continuously, sof on first pixel -> first win_valid comes 1 cycle after accepting (2,2), with centre=11, N=1, W=10, E=12, S=21, NW=0, NE=2, SW=20, SE=22. Exactly 6 windows. frame_done coincides with the window centred at 23.
2. Same frame with pix_valid toggled 1/0 randomly -> identical tap sequence and window count. No win_valid during gaps. Taps held during gaps.
3. Two back-to-back frames, second without sof -> second frame yields an identical 6-window sequence. No window appears for second-frame rows 0-1.
4. sof asserted at (2,3) of frame 1, then a full frame with values 100+10*r+c -> no valid window until new (2,2). First window centre=111. Total 6 windows after sof.
5. Assert rst for 1 cycle after accepting (3,1) -> all outputs 0 immediately. Subsequent pixel without sof is treated as (0,0). First window after 2 rows + 2 columns.
6. 256-pixel-wide frame (IMG_W=256) with col wrap at 255 -> no window at c=0 or c=1 of any line. Count = (IMG_H-2)*254.
